// File: rtl/mem_access_unit.sv
// Data-memory access unit at the MEM stage: runs one load/store over a req/ack bus,
// holding the pipeline until the access completes, and flags misaligned, illegal or timed-out accesses.
//
// state | meaning
// IDLE  | no access in flight; a legal access is latched, an illegal one faults immediately
// WAIT  | request on the bus, counting cycles until ack or timeout
// DONE  | result cycle: load_valid or timeout fault pulses, pipeline advances
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] mem_w_dataM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemtoRegM,
  input  logic [31:0] InsM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lo_q, lo_d;
  logic              is_load_q, is_load_d;
  logic              tout_q, tout_d;
  logic [31:0]       load_data_q, load_data_d;

  logic [2:0]  f3;
  logic        access, is_load, illegal, misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_fmt;
  logic        unused_ins;

  assign f3         = InsM[14:12];
  assign unused_ins = ^{InsM[31:15], InsM[11:0]};
  assign access     = MemWriteM | (MemtoRegM == 2'b01);
  // A store wins when both requests are present, so the load path never fires.
  assign is_load    = (MemtoRegM == 2'b01) & ~MemWriteM;
  assign illegal    = (f3 == 3'b011) | (f3[2:1] == 2'b11) | (MemWriteM & f3[2]);
  assign misaligned = ((f3[1:0] == 2'b01) & ALUOutM[0]) |
                      ((f3[1:0] == 2'b10) & (ALUOutM[1:0] != 2'b00));

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = mem_w_dataM;
    case (f3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ALUOutM[1:0];
        st_wdata = {4{mem_w_dataM[7:0]}};
      end
      2'b01: begin
        st_wstrb = ALUOutM[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{mem_w_dataM[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_half = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lo_q)
      2'd0:    rd_byte = dmem_rdata[7:0];
      2'd1:    rd_byte = dmem_rdata[15:8];
      2'd2:    rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    case (funct3_q)
      3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rd_fmt = {24'h0, rd_byte};
      3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  rd_fmt = {16'h0, rd_half};
      default: rd_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lo_d        = lo_q;
    is_load_d   = is_load_q;
    tout_d      = tout_q;
    load_data_d = load_data_q;
    stall_mem   = 1'b0;
    mem_fault   = 1'b0;
    load_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal | misaligned) begin
            mem_fault = 1'b1;
          end else begin
            stall_mem = 1'b1;
            addr_d    = {ALUOutM[31:2], 2'b00};
            wstrb_d   = MemWriteM ? st_wstrb : 4'b0000;
            wdata_d   = st_wdata;
            we_d      = MemWriteM;
            funct3_d  = f3;
            lo_d      = ALUOutM[1:0];
            is_load_d = is_load;
            cnt_d     = '0;
            tout_d    = 1'b0;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        stall_mem = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          if (is_load_q) load_data_d = rd_fmt;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        load_valid = is_load_q & ~tout_q;
        mem_fault  = tout_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      lo_q        <= '0;
      is_load_q   <= 1'b0;
      tout_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lo_q        <= lo_d;
      is_load_q   <= is_load_d;
      tout_q      <= tout_d;
      load_data_q <= load_data_d;
    end
  end

  assign dmem_req   = (state_q == WAIT);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wstrb = wstrb_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random accesses
// checked cycle by cycle against an arithmetic model of the access rules.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUOutM, mem_w_dataM, InsM, dmem_rdata;
  logic        MemWriteM, dmem_ack;
  logic [1:0]  MemtoRegM;
  logic        dmem_req, dmem_we, stall_mem, load_valid, mem_fault;
  logic [31:0] dmem_addr, dmem_wdata, load_data;
  logic [3:0]  dmem_wstrb;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ld_model = 32'h0;

  mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .ALUOutM(ALUOutM), .mem_w_dataM(mem_w_dataM),
    .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .InsM(InsM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stall_mem(stall_mem), .load_data(load_data),
    .load_valid(load_valid), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 0;
    if (st && f3 >= 4) return 0;
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << (a % 4));
      2'b01:   return 4'(3 << (a % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    case (f3[1:0])
      2'b00: begin
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 0 && v >= 32'h80) v = v - 32'h100;
      end
      2'b01: begin
        v = (rd >> (8 * (a % 4))) & 32'hFFFF;
        if (f3 == 1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    MemWriteM = 1'b0;
    MemtoRegM = 2'b00;
  endtask

  // One access from an IDLE cycle; ack_dly = WAIT cycle index of the ack, -1 = never.
  task automatic access(input bit st, input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd, input int ack_dly, input string nm);
    bit acc, bad, tout, ldv;
    int reqs, stalls, w;
    logic [31:0] ins;
    logic [1:0]  nonload [3];
    nonload = '{2'b00, 2'b10, 2'b11};
    ins = $urandom;
    ins[14:12] = f3;
    InsM = ins;
    ALUOutM = a;
    mem_w_dataM = d;
    MemWriteM = st;
    MemtoRegM = ld ? 2'b01 : nonload[$urandom_range(0, 2)];
    #1;
    acc = st || ld;
    bad = acc && !legal(st, f3, a);
    check({nm, " idle_stall"}, stall_mem, acc && !bad);
    check({nm, " idle_fault"}, mem_fault, bad);
    check({nm, " idle_req"}, dmem_req, 0);
    if (!acc || bad) begin
      tick();
      idle_inputs();
      #1;
      check({nm, " after_req"}, dmem_req, 0);
      check({nm, " after_fault"}, mem_fault, 0);
      check({nm, " after_stall"}, stall_mem, 0);
      return;
    end
    stalls = 1;
    reqs = 0;
    tout = 1;
    w = 0;
    while (w < TIMEOUT) begin
      tick();
      dmem_ack = (w == ack_dly);
      dmem_rdata = dmem_ack ? rd : $urandom;
      #1;
      check({nm, " wait_req"}, dmem_req, 1);
      check({nm, " wait_stall"}, stall_mem, 1);
      check({nm, " wait_addr"}, dmem_addr, a & ~32'h3);
      check({nm, " wait_we"}, dmem_we, st);
      check({nm, " wait_wstrb"}, dmem_wstrb, st ? exp_wstrb(f3, a) : 4'h0);
      if (st) check({nm, " wait_wdata"}, dmem_wdata, exp_wdata(f3, d));
      check({nm, " wait_lv"}, load_valid, 0);
      check({nm, " wait_fault"}, mem_fault, 0);
      if (dmem_req) reqs++;
      if (stall_mem) stalls++;
      if (w == ack_dly) begin
        tout = 0;
        break;
      end
      w++;
    end
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    #1;
    ldv = ld && !st && !tout;
    if (ldv) ld_model = exp_load(f3, a, rd);
    check({nm, " done_req"}, dmem_req, 0);
    check({nm, " done_stall"}, stall_mem, 0);
    check({nm, " done_lv"}, load_valid, ldv);
    check({nm, " done_fault"}, mem_fault, tout);
    check({nm, " load_data"}, load_data, ld_model);
    check({nm, " req_cycles"}, reqs, tout ? TIMEOUT : ack_dly + 1);
    check({nm, " stall_cycles"}, stalls, tout ? TIMEOUT + 1 : ack_dly + 2);
    tick();
    idle_inputs();
    #1;
    check({nm, " next_lv"}, load_valid, 0);
    check({nm, " next_fault"}, mem_fault, 0);
    check({nm, " next_req"}, dmem_req, 0);
  endtask

  initial begin
    logic [31:0] a;
    int kind, r, dly;
    logic [2:0] f3;
    rst = 1'b1;
    ALUOutM = '0; mem_w_dataM = '0; InsM = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst req", dmem_req, 0);
    check("rst stall", stall_mem, 0);
    check("rst addr", dmem_addr, 0);
    check("rst wstrb", dmem_wstrb, 0);
    check("rst wdata", dmem_wdata, 0);
    check("rst load_data", load_data, 0);
    check("rst lv", load_valid, 0);
    check("rst fault", mem_fault, 0);
    rst = 1'b0;
    tick();

    access(1, 0, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0, "sb");
    access(0, 1, 3'b000, 32'h2002, 32'h0, 32'h0080_FF00, 2, "lb");
    access(0, 1, 3'b100, 32'h2002, 32'h0, 32'h0080_FF00, 2, "lbu");
    access(0, 1, 3'b001, 32'h3003, 32'h0, 32'h0, 0, "lh_mis");
    access(1, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, "sw_mis");
    access(0, 1, 3'b010, 32'h3000, 32'h0, 32'h0, -1, "lw_tout");
    access(1, 0, 3'b001, 32'h4002, 32'h0000_1234, 32'h0, 0, "sh");
    access(0, 1, 3'b101, 32'h4002, 32'h0, 32'hBEEF_0000, 0, "lhu");
    access(1, 1, 3'b010, 32'h4004, 32'hCAFE_F00D, 32'h1111_2222, 1, "st_ld_both");
    access(0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, "none");

    // Reset during the second WAIT cycle, with a late ack afterwards.
    InsM = 32'h0000_2003;
    ALUOutM = 32'h5000;
    MemWriteM = 1'b0;
    MemtoRegM = 2'b01;
    tick();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h5555_AAAA;
    ld_model = 32'h0;
    #1;
    check("rstw req", dmem_req, 0);
    check("rstw stall", stall_mem, 0);
    check("rstw lv", load_valid, 0);
    check("rstw fault", mem_fault, 0);
    check("rstw addr", dmem_addr, 0);
    check("rstw load_data", load_data, 0);
    tick();
    dmem_ack = 1'b0;
    #1;
    check("rstw ack_lv", load_valid, 0);
    check("rstw ack_fault", mem_fault, 0);
    check("rstw ack_req", dmem_req, 0);
    check("rstw ack_load_data", load_data, 0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      r = $urandom_range(0, 11);
      dly = (r == 11) ? -1 : r % 6;
      access(kind[0], kind[1], f3, a, $urandom, $urandom, dly, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Consumer end of the EX/MEM pipeline register: reads the MEM-stage fields (address, store data, control, instruction word) and performs the actual data-memory load/store over a req/ack bus.
- Generates byte-lane strobes, store-data replication, and load sign/zero extension.
- Stalls the pipeline (the MEM register enable is driven low) until the access completes.
- Detects misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT without dmem_ack before fault (>=2).
- CNT_W, 5: width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ALUOutM  in  32  effective address
- mem_w_dataM  in  32  store data (rs2 value)
- MemWriteM  in  1  store request
- MemtoRegM  in  2  2'b01 = load; other values = no load
- InsM  in  32  instruction; funct3 = InsM[14:12]
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address {ALUOutM[31:2],2'b00}, latched
- dmem_wstrb  out  4  byte-lane write enables (0 for loads)
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with ack
- dmem_ack  in  1  one-cycle completion
- stall_mem  out  1  1 = hold pipeline (drive register en low)
- load_data  out  32  extended load result
- load_valid  out  1  one-cycle pulse, load_data valid
- mem_fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Access present when MemWriteM=1 or MemtoRegM==2'b01. If both are set, the store takes priority and load_valid is never pulsed.
- Sizes by funct3:
  - 000 lb/sb and 100 lbu: byte.
  - 001 lh/sh and 101 lhu: half; misaligned if addr[0]=1.
  - 010 lw/sw: word; misaligned if addr[1:0]!=0.
  - 011, 110, 111 are illegal; 100/101 on a store are illegal.
- Store lanes:
  - sb: wstrb=1<<addr[1:0], wdata={4{d[7:0]}}.
  - sh: wstrb=addr[1]?1100:0011, wdata={2{d[15:0]}}.
  - sw: wstrb=1111, wdata=d.
- Load extraction from the latched rdata using the latched addr[1:0]:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Byte lane k = rdata[8k+7:8k]; half = addr[1] ? rdata[31:16] : rdata[15:0].
- FSM states: IDLE, WAIT, DONE. Reset value: IDLE.
- IDLE:
  - No access: stall_mem=0.
  - Access and legal: stall_mem=1 (combinational). Latch addr, wstrb, wdata, we, funct3, addr[1:0]; clear counter; go to WAIT.
  - Access and illegal/misaligned: stall_mem=0, mem_fault=1 this cycle (combinational), no bus request, stay in IDLE.
- WAIT:
  - dmem_req=1 (registered) and stall_mem=1. Bus outputs are stable, taken from the latches.
  - Counter increments each cycle.
  - On dmem_ack: latch the formatted load_data (loads only) and go to DONE.
  - If counter reaches TIMEOUT_CYCLES-1 with no ack: drop req, set fault flag, go to DONE.
- DONE:
  - stall_mem=0, dmem_req=0.
  - load_valid=1 if the access was a load and did not time out; mem_fault=1 if it timed out.
  - Go to IDLE; the pipeline advances at this edge.
- Latency: with ack on the first WAIT cycle, an access occupies IDLE, WAIT, DONE (3 cycles, 2 stalled). Each extra ack delay adds one stall cycle.
- Back-to-back accesses: the next access is seen in the IDLE cycle after DONE, with no lost instruction.
- dmem_ack outside WAIT is ignored.
- load_data holds its value until the next load completes; it is not modified by stores.
- Reset values, including reset asserted mid-WAIT:
  - State returns to IDLE; counter and fault flag clear.
  - dmem_req, dmem_we, load_valid, mem_fault, stall_mem = 0.
  - dmem_addr, dmem_wstrb, dmem_wdata, load_data = 0.
  - An ack arriving after reset is ignored.
- The pipeline must not flush the MEM register while stall_mem=1. This unit does not observe the clear.

Test Plan:
- sb, addr=0x1003, data=0x000000A5, ack on first WAIT cycle -> wstrb=1000, wdata=0xA5A5A5A5, dmem_addr=0x1000, stall_mem high for exactly 2 cycles, no load_valid.
- lb, addr=0x2002, rdata=0x0080FF00, ack after 3 WAIT cycles -> load_data=0xFFFFFF80, load_valid single pulse in DONE, 4 stall cycles. Repeat as lbu -> 0x00000080.
- lh addr=0x3003 -> mem_fault pulse in same cycle, dmem_req never asserted, stall_mem=0. sw addr=0x3002 -> same response.
- lw, ack withheld, TIMEOUT_CYCLES=16 -> dmem_req high for exactly 16 cycles, then mem_fault pulse, load_valid=0, return to IDLE.
- Back-to-back sh addr=0x4002 data=0x1234 then lhu addr=0x4002 with rdata=0xBEEF0000 -> first access wstrb=1100 and wdata=0x12341234; second access load_data=0x0000BEEF; each access stalls 2 cycles.
- rst asserted on the second WAIT cycle, with ack in the following cycle -> dmem_req=0 and stall_mem=0 after the edge, no load_valid or mem_fault, state IDLE.
